ct_had_ddc_ctrl: RTL and testbench

- Sequencing controller for the HAD DDC (debug direct-download) datapath.
- Turns debugger JTAG DR updates of DADDR/DDATA into a fixed sequence of core instruction injections:
  - address phase: mv x1,x1 with ffy;
  - data phase: mv x2,x2 with ffy;
  - store phase: sd x2,0(x1).
- Drives the datapath select and address-increment strobes and handshakes with the core's debug-instruction execute path.
- Sits between the TAP state machine / IR decoder and ct_had_ddc_dp.

---
 rtl/ct_had_ddc_pkg.sv | 25 ++
 rtl/ct_had_ddc_wdt.sv | 38 +++
 rtl/ct_had_ddc_ctrl.sv | 155 +++++++++++++++
 tb/tb_ct_had_ddc_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ct_had_ddc_pkg.sv
// Shared definitions for the HAD DDC (debug direct-download) controller and datapath.
//   - sequencer state encodings
//   - default watchdog width / limit
//   - instruction words injected into the core for each phase
package ct_had_ddc_pkg;

  localparam int unsigned DDC_TO_W   = 8;
  localparam logic [7:0]  DDC_TO_MAX = 8'hFF;

  // mv x1,x1 (ffy), mv x2,x2 (ffy), sd x2,0(x1)
  localparam logic [31:0] DDC_INST_ADDR  = 32'h00008093;
  localparam logic [31:0] DDC_INST_DATA  = 32'h00010113;
  localparam logic [31:0] DDC_INST_STORE = 32'h0020b023;

  typedef enum logic [2:0] {
    DDC_IDLE   = 3'd0,
    DDC_A_REQ  = 3'd1,
    DDC_A_WAIT = 3'd2,
    DDC_D_REQ  = 3'd3,
    DDC_D_WAIT = 3'd4,
    DDC_S_REQ  = 3'd5,
    DDC_S_WAIT = 3'd6
  } ddc_state_e;

endpackage

// File: rtl/ct_had_ddc_wdt.sv
// Per-instruction completion watchdog for the DDC sequencer.
// Ports:
//   cpuclk, cpurst_b  clock, async active-low reset
//   wdt_clr           clear counter (issued on every REQ)
//   wdt_en            count this cycle (WAIT states)
//   wdt_expire        this counting cycle brings the count to TO_MAX
module ct_had_ddc_wdt
  import ct_had_ddc_pkg::*;
#(
  parameter int unsigned      TO_W   = DDC_TO_W,
  parameter logic [TO_W-1:0]  TO_MAX = TO_W'(DDC_TO_MAX)
) (
  input  logic cpuclk,
  input  logic cpurst_b,
  input  logic wdt_clr,
  input  logic wdt_en,
  output logic wdt_expire
);

  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_inc;

  assign cnt_inc = cnt + TO_W'(1);

  // Saturates at TO_MAX; the sequencer leaves WAIT on the same cycle the
  // limit is reached, so the count parks at TO_MAX in IDLE.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      cnt <= '0;
    else if (wdt_clr)
      cnt <= '0;
    else if (wdt_en && (cnt != TO_MAX))
      cnt <= cnt_inc;
  end

  assign wdt_expire = wdt_en && (cnt != TO_MAX) && (cnt_inc == TO_MAX);

endmodule

// File: rtl/ct_had_ddc_ctrl.sv
// Sequencing controller for the HAD DDC datapath.
// Turns Update-DR of DADDR/DDATA into injected instruction sequences:
//   DADDR: address phase (mv x1,x1)
//   DDATA: data phase (mv x2,x2) then store phase (sd x2,0(x1)) + DADDR += 8
// Ports:
//   cpuclk, cpurst_b                 clock, async active-low reset
//   hcr_ddc_en                       DDC mode enable; low forces idle
//   x_sm_xx_update_dr_en             Update-DR strobe
//   ir_xx_daddr_reg_sel/ddata_reg_sel IR register selects
//   rtu_had_ddc_inst_cmplt           injected instruction retired
//   ddc_ctrl_dp_addr_sel/data_sel    datapath phase selects
//   ddc_ctrl_dp_addr_gen             DADDR increment strobe
//   ddc_xx_update_ir                 start execution of injected instruction
//   ddc_ctrl_busy                    sequence in progress
//   ddc_ctrl_ovr_err, ddc_ctrl_to_err sticky overrun / watchdog flags
module ct_had_ddc_ctrl
  import ct_had_ddc_pkg::*;
#(
  parameter int unsigned      TO_W   = DDC_TO_W,
  parameter logic [TO_W-1:0]  TO_MAX = TO_W'(DDC_TO_MAX)
) (
  input  logic cpuclk,
  input  logic cpurst_b,
  input  logic hcr_ddc_en,
  input  logic x_sm_xx_update_dr_en,
  input  logic ir_xx_daddr_reg_sel,
  input  logic ir_xx_ddata_reg_sel,
  input  logic rtu_had_ddc_inst_cmplt,
  output logic ddc_ctrl_dp_addr_sel,
  output logic ddc_ctrl_dp_data_sel,
  output logic ddc_ctrl_dp_addr_gen,
  output logic ddc_xx_update_ir,
  output logic ddc_ctrl_busy,
  output logic ddc_ctrl_ovr_err,
  output logic ddc_ctrl_to_err
);

  ddc_state_e state_q, state_nxt;
  logic daddr_trig, ddata_trig;
  logic wdt_clr, wdt_en, wdt_expire;
  logic to_hit;

  assign daddr_trig = x_sm_xx_update_dr_en & ir_xx_daddr_reg_sel & hcr_ddc_en;
  assign ddata_trig = x_sm_xx_update_dr_en & ir_xx_ddata_reg_sel & hcr_ddc_en;

  ct_had_ddc_wdt #(
    .TO_W   (TO_W),
    .TO_MAX (TO_MAX)
  ) x_ct_had_ddc_wdt (
    .cpuclk     (cpuclk),
    .cpurst_b   (cpurst_b),
    .wdt_clr    (wdt_clr),
    .wdt_en     (wdt_en),
    .wdt_expire (wdt_expire)
  );

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      state_q <= DDC_IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt            = state_q;
    ddc_ctrl_dp_addr_sel = 1'b0;
    ddc_ctrl_dp_data_sel = 1'b0;
    ddc_ctrl_dp_addr_gen = 1'b0;
    ddc_xx_update_ir     = 1'b0;
    wdt_clr              = 1'b0;
    wdt_en               = 1'b0;
    to_hit               = 1'b0;
    case (state_q)
      DDC_IDLE: begin
        if (daddr_trig)
          state_nxt = DDC_A_REQ;
        else if (ddata_trig)
          state_nxt = DDC_D_REQ;
      end
      DDC_A_REQ: begin
        ddc_ctrl_dp_addr_sel = 1'b1;
        ddc_xx_update_ir     = 1'b1;
        wdt_clr              = 1'b1;
        state_nxt            = DDC_A_WAIT;
      end
      DDC_A_WAIT: begin
        ddc_ctrl_dp_addr_sel = 1'b1;
        wdt_en               = 1'b1;
        if (rtu_had_ddc_inst_cmplt)
          state_nxt = DDC_IDLE;
        else if (wdt_expire) begin
          to_hit    = 1'b1;
          state_nxt = DDC_IDLE;
        end
      end
      DDC_D_REQ: begin
        ddc_ctrl_dp_data_sel = 1'b1;
        ddc_xx_update_ir     = 1'b1;
        wdt_clr              = 1'b1;
        state_nxt            = DDC_D_WAIT;
      end
      DDC_D_WAIT: begin
        ddc_ctrl_dp_data_sel = 1'b1;
        wdt_en               = 1'b1;
        if (rtu_had_ddc_inst_cmplt)
          state_nxt = DDC_S_REQ;
        else if (wdt_expire) begin
          to_hit    = 1'b1;
          state_nxt = DDC_IDLE;
        end
      end
      DDC_S_REQ: begin
        ddc_xx_update_ir = 1'b1;
        wdt_clr          = 1'b1;
        state_nxt        = DDC_S_WAIT;
      end
      DDC_S_WAIT: begin
        wdt_en = 1'b1;
        if (rtu_had_ddc_inst_cmplt) begin
          ddc_ctrl_dp_addr_gen = 1'b1;
          state_nxt            = DDC_IDLE;
        end else if (wdt_expire) begin
          to_hit    = 1'b1;
          state_nxt = DDC_IDLE;
        end
      end
      default: state_nxt = DDC_IDLE;
    endcase
    // Mode disable overrides everything: pulses and a same-cycle cmplt are dropped.
    if (!hcr_ddc_en) begin
      state_nxt            = DDC_IDLE;
      ddc_xx_update_ir     = 1'b0;
      ddc_ctrl_dp_addr_gen = 1'b0;
      to_hit               = 1'b0;
    end
  end

  assign ddc_ctrl_busy = (state_q != DDC_IDLE);

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ddc_ctrl_ovr_err <= 1'b0;
      ddc_ctrl_to_err  <= 1'b0;
    end else if (!hcr_ddc_en) begin
      ddc_ctrl_ovr_err <= 1'b0;
      ddc_ctrl_to_err  <= 1'b0;
    end else begin
      if (ddc_ctrl_busy && (daddr_trig || ddata_trig))
        ddc_ctrl_ovr_err <= 1'b1;
      if (to_hit)
        ddc_ctrl_to_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_had_ddc_ctrl.sv
// Directed bench for ct_had_ddc_ctrl. Outputs are packed per cycle as
// {addr_sel, data_sel, addr_gen, update_ir, busy, ovr_err, to_err}.
module tb_ct_had_ddc_ctrl;

  logic cpuclk = 1'b0;
  logic cpurst_b;
  logic hcr_ddc_en;
  logic x_sm_xx_update_dr_en;
  logic ir_xx_daddr_reg_sel;
  logic ir_xx_ddata_reg_sel;
  logic rtu_had_ddc_inst_cmplt;
  logic ddc_ctrl_dp_addr_sel;
  logic ddc_ctrl_dp_data_sel;
  logic ddc_ctrl_dp_addr_gen;
  logic ddc_xx_update_ir;
  logic ddc_ctrl_busy;
  logic ddc_ctrl_ovr_err;
  logic ddc_ctrl_to_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 cpuclk = ~cpuclk;

  ct_had_ddc_ctrl #(
    .TO_W   (8),
    .TO_MAX (8'h04)
  ) dut (
    .cpuclk                 (cpuclk),
    .cpurst_b               (cpurst_b),
    .hcr_ddc_en             (hcr_ddc_en),
    .x_sm_xx_update_dr_en   (x_sm_xx_update_dr_en),
    .ir_xx_daddr_reg_sel    (ir_xx_daddr_reg_sel),
    .ir_xx_ddata_reg_sel    (ir_xx_ddata_reg_sel),
    .rtu_had_ddc_inst_cmplt (rtu_had_ddc_inst_cmplt),
    .ddc_ctrl_dp_addr_sel   (ddc_ctrl_dp_addr_sel),
    .ddc_ctrl_dp_data_sel   (ddc_ctrl_dp_data_sel),
    .ddc_ctrl_dp_addr_gen   (ddc_ctrl_dp_addr_gen),
    .ddc_xx_update_ir       (ddc_xx_update_ir),
    .ddc_ctrl_busy          (ddc_ctrl_busy),
    .ddc_ctrl_ovr_err       (ddc_ctrl_ovr_err),
    .ddc_ctrl_to_err        (ddc_ctrl_to_err)
  );

  logic [6:0] outv;
  assign outv = {ddc_ctrl_dp_addr_sel, ddc_ctrl_dp_data_sel, ddc_ctrl_dp_addr_gen,
                 ddc_xx_update_ir, ddc_ctrl_busy, ddc_ctrl_ovr_err, ddc_ctrl_to_err};

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Drive one cycle's inputs {update_dr, daddr_sel, ddata_sel, cmplt} just
  // after the rising edge, check outputs mid-cycle, then advance a cycle.
  task automatic cyc(input string tag, input logic [3:0] in, input logic [6:0] exp);
    {x_sm_xx_update_dr_en, ir_xx_daddr_reg_sel, ir_xx_ddata_reg_sel, rtu_had_ddc_inst_cmplt} = in;
    #3;
    check_val(tag, outv, exp);
    @(posedge cpuclk);
    #1;
  endtask

  localparam logic [3:0] I_NONE  = 4'b0000;
  localparam logic [3:0] I_DADDR = 4'b1100;
  localparam logic [3:0] I_DDATA = 4'b1010;
  localparam logic [3:0] I_BOTH  = 4'b1110;
  localparam logic [3:0] I_CMPLT = 4'b0001;

  initial begin
    cpurst_b   = 1'b0;
    hcr_ddc_en = 1'b1;
    {x_sm_xx_update_dr_en, ir_xx_daddr_reg_sel, ir_xx_ddata_reg_sel, rtu_had_ddc_inst_cmplt} = '0;
    #12;
    check_val("reset_state", outv, 7'b0000000);
    @(posedge cpuclk);
    #1;
    cpurst_b = 1'b1;

    // cmplt in IDLE is ignored
    cyc("idle_cmplt",   I_CMPLT, 7'b0000000);
    cyc("idle_after",   I_NONE,  7'b0000000);

    // DADDR write, cmplt at T+3
    cyc("a_T",    I_DADDR, 7'b0000000);
    cyc("a_T1",   I_NONE,  7'b1001100);
    cyc("a_T2",   I_NONE,  7'b1000100);
    cyc("a_T3",   I_CMPLT, 7'b1000100);
    cyc("a_T4",   I_NONE,  7'b0000000);

    // DDATA write, cmplt at T+2 and T+5
    cyc("d_T",    I_DDATA, 7'b0000000);
    cyc("d_T1",   I_NONE,  7'b0101100);
    cyc("d_T2",   I_CMPLT, 7'b0100100);
    cyc("d_T3",   I_NONE,  7'b0001100);
    cyc("d_T4",   I_NONE,  7'b0000100);
    cyc("d_T5",   I_CMPLT, 7'b0010100);
    cyc("d_T6",   I_NONE,  7'b0000000);

    // Same, with a second DDATA write (plus cmplt) at T+2
    cyc("o_T",    I_DDATA, 7'b0000000);
    cyc("o_T1",   I_NONE,  7'b0101100);
    cyc("o_T2",   I_DDATA | I_CMPLT, 7'b0100100);
    cyc("o_T3",   I_NONE,  7'b0001110);
    cyc("o_T4",   I_NONE,  7'b0000110);
    cyc("o_T5",   I_CMPLT, 7'b0010110);
    cyc("o_T6",   I_NONE,  7'b0000010);

    // Both selects: DADDR wins
    cyc("b_T",    I_BOTH,  7'b0000010);
    cyc("b_T1",   I_NONE,  7'b1001110);
    cyc("b_T2",   I_CMPLT, 7'b1000110);
    cyc("b_T3",   I_NONE,  7'b0000010);

    // Mode disable clears sticky overrun
    hcr_ddc_en = 1'b0;
    cyc("dis_T",  I_NONE,  7'b0000010);
    hcr_ddc_en = 1'b1;
    cyc("dis_T1", I_NONE,  7'b0000000);

    // Watchdog: no cmplt after D_REQ, abort after 4 wait cycles
    cyc("w_T",    I_DDATA, 7'b0000000);
    cyc("w_T1",   I_NONE,  7'b0101100);
    cyc("w_T2",   I_NONE,  7'b0100100);
    cyc("w_T3",   I_NONE,  7'b0100100);
    cyc("w_T4",   I_NONE,  7'b0100100);
    cyc("w_T5",   I_NONE,  7'b0100100);
    cyc("w_T6",   I_NONE,  7'b0000001);
    cyc("w_T7",   I_CMPLT, 7'b0000001);

    // hcr_ddc_en dropped in S_WAIT together with cmplt
    cyc("h_T",    I_DDATA, 7'b0000001);
    cyc("h_T1",   I_DDATA, 7'b0101101);
    cyc("h_T2",   I_CMPLT, 7'b0100111);
    cyc("h_T3",   I_NONE,  7'b0001111);
    hcr_ddc_en = 1'b0;
    cyc("h_T4",   I_CMPLT, 7'b0000111);
    hcr_ddc_en = 1'b1;
    cyc("h_T5",   I_NONE,  7'b0000000);
    cyc("h_T6",   I_NONE,  7'b0000000);

    // Async reset in D_WAIT, then a clean DADDR sequence
    cyc("r_T",    I_DDATA, 7'b0000000);
    cyc("r_T1",   I_DDATA, 7'b0101100);
    {x_sm_xx_update_dr_en, ir_xx_daddr_reg_sel, ir_xx_ddata_reg_sel, rtu_had_ddc_inst_cmplt} = '0;
    #2;
    check_val("r_T2_pre", outv, 7'b0100110);
    cpurst_b = 1'b0;
    #1;
    check_val("r_T2_rst", outv, 7'b0000000);
    @(posedge cpuclk);
    #1;
    check_val("r_held", outv, 7'b0000000);
    cpurst_b = 1'b1;
    @(posedge cpuclk);
    #1;
    cyc("ra_T",   I_DADDR, 7'b0000000);
    cyc("ra_T1",  I_NONE,  7'b1001100);
    cyc("ra_T2",  I_CMPLT, 7'b1000100);
    cyc("ra_T3",  I_NONE,  7'b0000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
